// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio path: song ROM, scheduler and tone generator.
package audio_pkg;

    localparam int unsigned NOTE_W_DEF   = 5;
    localparam int unsigned TICK_DIV_DEF = 12500000;
    localparam int unsigned SFX_LEN_W    = 3;

    typedef logic [NOTE_W_DEF-1:0] note_t;

    localparam note_t NOTE_REST = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BGM  = 2'd1,
        SFX  = 2'd2
    } state_t;

endpackage

// File: rtl/audio_tick_gen.sv
// Note-step tick: counts 0..TICK_DIV-1 and flags the last count; a synchronous clear holds it at 0.
module audio_tick_gen
    import audio_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last   = (r_cnt == CNT_LAST);
    assign o_tick_c = w_last && !i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/audio_scheduler.sv
// Arbitrates the tone generator between background music and one-shot sound effects,
// advancing the song on every note-step tick while either source is playing.
module audio_scheduler
    import audio_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned NOTE_W   = NOTE_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NOTE_W-1:0]    bgm_note,
    output logic                 bgm_adv,
    input  logic                 sfx_req,
    input  logic [NOTE_W-1:0]    sfx_note,
    input  logic [SFX_LEN_W-1:0] sfx_len,
    output logic                 sfx_ack,
    output logic [NOTE_W-1:0]    tone_note,
    output logic                 tone_mute,
    output logic                 tone_load,
    output logic                 src_sfx
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NOTE_W-1:0]    r_tone_note;
    logic [NOTE_W-1:0]    w_note_nxt;
    logic [SFX_LEN_W-1:0] r_rem;
    logic [SFX_LEN_W-1:0] w_rem_nxt;
    logic [SFX_LEN_W-1:0] w_sfx_len_eff;
    logic                 w_adv_nxt;
    logic                 r_bgm_adv;
    logic                 r_tone_mute;
    logic                 r_tone_load;
    logic                 r_src_sfx;
    logic                 w_tick;
    logic                 w_tick_clr;
    logic                 w_accept;

    // Tick time only runs while a source is playing.
    assign w_tick_clr = (r_state == IDLE) || !enable;

    audio_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_tick_clr),
        .o_tick_c (w_tick)
    );

    assign w_accept      = enable && sfx_req && (r_state != IDLE);
    assign w_sfx_len_eff = (sfx_len == '0) ? SFX_LEN_W'(1) : sfx_len;

    // FSM state register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tone_note <= '0;
            r_rem       <= '0;
            r_bgm_adv   <= 1'b0;
            r_tone_load <= 1'b0;
            r_tone_mute <= 1'b1;
            r_src_sfx   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tone_note <= w_note_nxt;
            r_rem       <= w_rem_nxt;
            r_bgm_adv   <= w_adv_nxt;
            r_tone_load <= (w_note_nxt != r_tone_note);
            r_tone_mute <= (w_state_nxt == IDLE) || (w_note_nxt == NOTE_W'(NOTE_REST));
            r_src_sfx   <= (w_state_nxt == SFX);
        end
    end

    // Next-state, note mux and remaining-tick bookkeeping; a new request always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = r_tone_note;
        w_rem_nxt   = r_rem;
        w_adv_nxt   = 1'b0;

        if (!enable) begin
            w_state_nxt = IDLE;
            w_rem_nxt   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt = BGM;
                    w_note_nxt  = bgm_note;
                    w_adv_nxt   = 1'b1;
                end
                BGM: begin
                    if (w_tick) begin
                        w_adv_nxt  = 1'b1;
                        w_note_nxt = bgm_note;
                    end
                    if (w_accept) begin
                        w_state_nxt = SFX;
                        w_note_nxt  = sfx_note;
                        w_rem_nxt   = w_sfx_len_eff;
                    end
                end
                SFX: begin
                    if (w_tick) begin
                        w_adv_nxt = 1'b1;
                        if (r_rem <= SFX_LEN_W'(1)) begin
                            w_state_nxt = BGM;
                            w_note_nxt  = bgm_note;
                            w_rem_nxt   = '0;
                        end else begin
                            w_rem_nxt = r_rem - SFX_LEN_W'(1);
                        end
                    end
                    if (w_accept) begin
                        w_state_nxt = SFX;
                        w_note_nxt  = sfx_note;
                        w_rem_nxt   = w_sfx_len_eff;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_rem_nxt   = '0;
                end
            endcase
        end
    end

    assign sfx_ack   = w_accept;
    assign bgm_adv   = r_bgm_adv;
    assign tone_note = r_tone_note;
    assign tone_mute = r_tone_mute;
    assign tone_load = r_tone_load;
    assign src_sfx   = r_src_sfx;

endmodule

// File: tb/tb_audio_scheduler.sv
// Directed bench for audio_scheduler with TICK_DIV=4: per-cycle expectations queued by the driver,
// compared by a negedge monitor.
module tb_audio_scheduler;

    localparam int unsigned NW = 5;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [NW-1:0] bgm_note;
    logic          bgm_adv;
    logic          sfx_req;
    logic [NW-1:0] sfx_note;
    logic [2:0]    sfx_len;
    logic          sfx_ack;
    logic [NW-1:0] tone_note;
    logic          tone_mute;
    logic          tone_load;
    logic          src_sfx;

    typedef struct {
        bit            chk;
        int            step;
        logic [NW-1:0] note;
        logic          mute;
        logic          load;
        logic          adv;
        logic          ack;
        logic          src;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   checks   = 0;
    int   errors   = 0;
    int   adv_seen = 0;
    int   step_no  = 0;
    bit   done     = 1'b0;
    bit   fin_done = 1'b0;

    audio_scheduler #(
        .TICK_DIV (4),
        .NOTE_W   (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bgm_note  (bgm_note),
        .bgm_adv   (bgm_adv),
        .sfx_req   (sfx_req),
        .sfx_note  (sfx_note),
        .sfx_len   (sfx_len),
        .sfx_ack   (sfx_ack),
        .tone_note (tone_note),
        .tone_mute (tone_mute),
        .tone_load (tone_load),
        .src_sfx   (src_sfx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue this cycle's expectation, then move to the next cycle (posedge + 1).
    task automatic cyc(input bit chk, input logic [NW-1:0] n, input logic m, input logic l,
                       input logic a, input logic k, input logic s);
        exp_t e;
        e.chk  = chk;
        e.step = step_no;
        e.note = n;
        e.mute = m;
        e.load = l;
        e.adv  = a;
        e.ack  = k;
        e.src  = s;
        sb_q.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic req(input logic [NW-1:0] n, input logic [2:0] len);
        sfx_req  = 1'b1;
        sfx_note = n;
        sfx_len  = len;
    endtask

    // Monitor: compare outputs against the queued expectation for this cycle.
    always @(negedge clk) begin
        if (bgm_adv === 1'b1) adv_seen++;
        if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            if (m_e.chk) begin
                checks++;
                if ({tone_note, tone_mute, tone_load, bgm_adv, sfx_ack, src_sfx} !==
                    {m_e.note, m_e.mute, m_e.load, m_e.adv, m_e.ack, m_e.src}) begin
                    errors++;
                    $display("FAIL step%0d: got note=%0d mute=%b load=%b adv=%b ack=%b src=%b, expected note=%0d mute=%b load=%b adv=%b ack=%b src=%b",
                             m_e.step, tone_note, tone_mute, tone_load, bgm_adv, sfx_ack, src_sfx,
                             m_e.note, m_e.mute, m_e.load, m_e.adv, m_e.ack, m_e.src);
                end
            end
        end
        if (done && !fin_done) begin
            fin_done = 1'b1;
            checks++;
            if (adv_seen != 16) begin
                errors++;
                $display("FAIL adv_count: got %0d pulses, expected 16", adv_seen);
            end
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL sb_drain: got %0d leftover entries, expected 0", sb_q.size());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        bgm_note = '0;
        sfx_req  = 1'b1;
        sfx_note = 5'd1;
        sfx_len  = 3'd1;
        @(posedge clk);
        #1;
        // reset values, request ignored
        cyc(1, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(1, 0, 1, 0, 0, 0, 0);

        // C0: enable in IDLE with a request present: no ack, go to BGM
        enable   = 1'b1;
        bgm_note = 5'd3;
        req(5'd12, 3'd2);
        cyc(1, 0, 1, 0, 0, 0, 0);
        sfx_req = 1'b0;
        cyc(1, 3, 0, 1, 1, 0, 0);                   // C1
        cyc(1, 3, 0, 0, 0, 0, 0);                   // C2
        skip(2);                                    // C3-C4
        cyc(1, 3, 0, 0, 1, 0, 0);                   // C5 same-note rewrite: no load

        // SFX note 12 for 2 ticks
        req(5'd12, 3'd2);
        bgm_note = 5'd7;
        cyc(1, 3, 0, 0, 0, 1, 0);                   // C6 ack
        sfx_req = 1'b0;
        cyc(1, 12, 0, 1, 0, 0, 1);                  // C7
        skip(1);                                    // C8
        cyc(1, 12, 0, 0, 1, 0, 1);                  // C9
        skip(3);                                    // C10-C12
        cyc(1, 7, 0, 1, 1, 0, 0);                   // C13 back to music

        // zero length behaves as one tick
        req(5'd9, 3'd0);
        cyc(1, 7, 0, 0, 0, 1, 0);                   // C14
        sfx_req = 1'b0;
        cyc(1, 9, 0, 1, 0, 0, 1);                   // C15
        skip(1);                                    // C16
        cyc(1, 7, 0, 1, 1, 0, 0);                   // C17

        // new request on the terminal tick of a running SFX
        req(5'd5, 3'd1);
        cyc(1, 7, 0, 0, 0, 1, 0);                   // C18
        sfx_req = 1'b0;
        cyc(1, 5, 0, 1, 0, 0, 1);                   // C19
        req(5'd15, 3'd3);
        cyc(1, 5, 0, 0, 0, 1, 1);                   // C20 terminal tick + request
        sfx_req = 1'b0;
        cyc(1, 15, 0, 1, 1, 0, 1);                  // C21
        skip(3);                                    // C22-C24
        cyc(1, 15, 0, 0, 1, 0, 1);                  // C25
        skip(3);                                    // C26-C28
        cyc(1, 15, 0, 0, 1, 0, 1);                  // C29
        skip(3);                                    // C30-C32
        cyc(1, 7, 0, 1, 1, 0, 0);                   // C33

        // rest note mutes; repeated rest gives no load
        bgm_note = 5'd0;
        skip(3);                                    // C34-C36
        cyc(1, 0, 1, 1, 1, 0, 0);                   // C37
        skip(3);                                    // C38-C40
        cyc(1, 0, 1, 0, 1, 0, 0);                   // C41
        skip(2);                                    // C42-C43

        // request coinciding with a BGM tick: SFX note wins, adv still pulses
        req(5'd11, 3'd1);
        cyc(1, 0, 1, 0, 0, 1, 0);                   // C44
        sfx_req = 1'b0;
        cyc(1, 11, 0, 1, 1, 0, 1);                  // C45
        skip(3);                                    // C46-C48
        cyc(1, 0, 1, 1, 1, 0, 0);                   // C49

        // enable dropped mid-SFX together with a request
        req(5'd6, 3'd3);
        cyc(1, 0, 1, 0, 0, 1, 0);                   // C50
        sfx_req = 1'b0;
        cyc(1, 6, 0, 1, 0, 0, 1);                   // C51
        skip(1);                                    // C52
        enable = 1'b0;
        req(5'd13, 3'd2);
        cyc(1, 6, 0, 0, 1, 0, 1);                   // C53 no ack
        for (int i = 0; i < 7; i++) cyc(1, 6, 1, 0, 0, 0, 0);   // C54-C60 held, muted

        // re-enable, start an SFX, then async reset mid-cycle
        enable   = 1'b1;
        sfx_req  = 1'b0;
        bgm_note = 5'd4;
        cyc(1, 6, 1, 0, 0, 0, 0);                   // C61
        cyc(1, 4, 0, 1, 1, 0, 0);                   // C62
        req(5'd2, 3'd3);
        cyc(1, 4, 0, 0, 0, 1, 0);                   // C63
        sfx_req = 1'b0;
        cyc(1, 2, 0, 1, 0, 0, 1);                   // C64
        skip(1);                                    // C65
        cyc(1, 2, 0, 0, 1, 0, 1);                   // C66
        req(5'd8, 3'd2);
        #1;
        rst_n = 1'b0;
        cyc(1, 0, 1, 0, 0, 0, 0);                   // C67 reset takes effect before the edge
        cyc(1, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        enable = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 0, 0);

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_scheduler.md
Name: audio_scheduler

Overview:
Sequences the shared square-wave tone generator between background-music playback and game sound effects (tile hit/miss).
- Generates the note-step tick.
- Advances the song note source.
- Accepts one-shot SFX requests that preempt the music for a programmable number of ticks.
- Drives the selected note index and mute to the tone generator.

Sits between the song note ROM / game FSM and the tone generator.

Parameters:
TICK_DIV, 12500000, clk cycles per note step (4 Hz at 50 MHz); minimum 2
NOTE_W, 5, note index width; index 0 = rest

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  game running; 0 = mute and hold
bgm_note  in  NOTE_W  current song note from ROM
bgm_adv  out  1  one-cycle pulse: ROM advances address
sfx_req  in  1  level/pulse SFX request
sfx_note  in  NOTE_W  SFX note, sampled on acceptance
sfx_len  in  3  SFX duration in ticks, sampled on acceptance; 0 treated as 1
sfx_ack  out  1  one-cycle pulse: request accepted
tone_note  out  NOTE_W  note index to tone generator
tone_mute  out  1  1 = silence
tone_load  out  1  one-cycle pulse when tone_note changes value
src_sfx  out  1  1 = SFX currently owns the generator

Behaviour:
- One clock, reset is asynchronous and active-low (rst_n); all state in clk domain.
- Reset values:
  - state IDLE, tick counter 0, remaining-tick counter 0.
  - bgm_adv/sfx_ack/tone_load/src_sfx = 0, tone_note = 0, tone_mute = 1.
- Tick: counter 0..TICK_DIV-1; tick pulses on the cycle the counter equals TICK_DIV-1, then wraps to 0. Counter is held at 0 in IDLE.
- FSM:
  - IDLE:
    - enable=1 -> BGM. On the transition cycle: tone_note<=bgm_note, bgm_adv=1, tone_mute updated.
    - sfx_req in IDLE: ignored, no ack.
  - BGM:
    - On tick: bgm_adv=1 and tone_note<=bgm_note, sampling the value present on that cycle. The ROM updates bgm_note after bgm_adv.
    - sfx_req=1 -> SFX. Same cycle: sfx_ack=1, tone_note<=sfx_note, rem<=max(sfx_len,1), src_sfx<=1.
    - sfx_req and tick in the same cycle: SFX wins tone_note; bgm_adv still pulses.
  - SFX:
    - Music time keeps running: bgm_adv pulses on every tick, but tone_note is not updated from bgm_note.
    - On tick: rem decrements. When rem==1 at tick -> BGM. Same cycle: tone_note<=bgm_note, src_sfx<=0.
    - sfx_req in SFX: newest request wins. Ack, reload note and rem, stay in SFX. This also applies on the terminal tick; the request takes priority over the return to BGM.
  - Any state, enable=0 -> IDLE next cycle.
    - tone_mute=1, src_sfx=0, rem cleared, tick counter cleared.
    - Pending request dropped with no ack; tone_note holds its last value.
- tone_mute = (state==IDLE) or (tone_note==0); registered with tone_note.
- tone_load = 1 exactly in the cycle tone_note takes a value different from its previous value; no pulse on a same-value rewrite.
- Reset asserted mid-SFX: immediate return to reset values; no ack or adv glitch after release.
- Latency: request-to-ack = 0 cycles (combinational on the registered state). Request to new tone_note = 1 cycle.

Decomposition:
- Package audio_pkg:
  - note_t (NOTE_W bits), NOTE_REST=0.
  - State enum {IDLE, BGM, SFX}.
  - Default TICK_DIV.
  - Shared with the song ROM and the tone generator.
- One sub-module, audio_tick_gen: parameterised TICK_DIV counter with synchronous clear input and tick output.
- FSM, rem counter and note muxing live in audio_scheduler.

Test Plan (TICK_DIV=4):
1. Reset, then enable=1 with bgm_note=3 -> next cycle tone_note=3, tone_load=1, tone_mute=0, bgm_adv=1. bgm_adv then pulses every 4 cycles.
2. In BGM, sfx_req with sfx_note=12, sfx_len=2 -> sfx_ack same cycle, tone_note=12, src_sfx=1. Exactly 2 ticks later tone_note=current bgm_note, src_sfx=0. bgm_adv count unchanged vs. a no-SFX run.
3. sfx_len=0, sfx_note=9 -> SFX lasts exactly 1 tick.
4. New sfx_req (note 15, len 3) on the terminal tick of a running SFX -> ack, tone_note=15, stays SFX for 3 more ticks.
5. bgm_note=0 during BGM -> tone_mute=1. Same note repeated across ticks -> no tone_load pulse.
6. enable dropped mid-SFX together with sfx_req -> no ack, IDLE next cycle, tone_mute=1, no bgm_adv until re-enable. Then rst_n pulsed low asynchronously mid-tick -> all outputs return to reset values immediately.
